// File: rtl/spi_proto_pkg.sv
// Shared protocol definitions for the host SPI link: opcodes, command and
// response codes, the frame FSM state type and the opcode decoder.
package spi_proto_pkg;

    // Frame opcodes (first byte of every SS frame)
    localparam logic [7:0] OP_WR_CMD    = 8'hC0;
    localparam logic [7:0] OP_WR_DATA   = 8'hC2;
    localparam logic [7:0] OP_RD_RESP   = 8'h81;
    localparam logic [7:0] OP_RD_STREAM = 8'h03;

    // Command codes carried in cmd_word
    localparam logic [31:0] CMD_NOP            = 32'd0;
    localparam logic [31:0] CMD_RESET          = 32'd1;
    localparam logic [31:0] CMD_ARM            = 32'd2;
    localparam logic [31:0] CMD_ARM_ON_STEP    = 32'd3;
    localparam logic [31:0] CMD_DISARM         = 32'd4;
    localparam logic [31:0] CMD_STEP           = 32'd5;
    localparam logic [31:0] CMD_RUN            = 32'd6;
    localparam logic [31:0] CMD_HALT           = 32'd7;
    localparam logic [31:0] CMD_SET_TRIG_VALUE = 32'd8;
    localparam logic [31:0] CMD_SET_TRIG_MASK  = 32'd9;
    localparam logic [31:0] CMD_SET_DELAY      = 32'd10;
    localparam logic [31:0] CMD_SET_DEPTH      = 32'd11;
    localparam logic [31:0] CMD_SET_CLKDIV     = 32'd12;
    localparam logic [31:0] CMD_CLEAR_BUF      = 32'd13;
    localparam logic [31:0] CMD_GET_STATUS     = 32'd14;

    // Response codes presented on resp_word
    localparam logic [31:0] RESP_IDLE       = 32'd0;
    localparam logic [31:0] RESP_ARMED      = 32'd1;
    localparam logic [31:0] RESP_TRIGGERED  = 32'd2;
    localparam logic [31:0] RESP_CAPTURING  = 32'd3;
    localparam logic [31:0] RESP_DONE       = 32'd4;
    localparam logic [31:0] RESP_OK         = 32'd5;
    localparam logic [31:0] RESP_BUSY       = 32'd6;
    localparam logic [31:0] RESP_ERR_OPCODE = 32'd7;
    localparam logic [31:0] RESP_ERR_ARG    = 32'd8;
    localparam logic [31:0] RESP_ERR_STATE  = 32'd9;
    localparam logic [31:0] RESP_OVERFLOW   = 32'd10;
    localparam logic [31:0] RESP_UNDERFLOW  = 32'd11;
    localparam logic [31:0] RESP_STEPPING   = 32'd12;
    localparam logic [31:0] RESP_HALTED     = 32'd13;
    localparam logic [31:0] RESP_UNKNOWN    = 32'd14;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_OPCODE    = 3'd1,
        ST_WR_CMD    = 3'd2,
        ST_WR_DATA   = 3'd3,
        ST_RD_RESP   = 3'd4,
        ST_RD_STREAM = 3'd5,
        ST_DISCARD   = 3'd6
    } spi_state_e;

    // Map a completed opcode byte to the frame state that handles the payload
    function automatic spi_state_e decode_opcode(input logic [7:0] op);
        spi_state_e st;
        case (op)
            OP_WR_CMD:    st = ST_WR_CMD;
            OP_WR_DATA:   st = ST_WR_DATA;
            OP_RD_RESP:   st = ST_RD_RESP;
            OP_RD_STREAM: st = ST_RD_STREAM;
            default:      st = ST_DISCARD;
        endcase
        return st;
    endfunction

endpackage

// File: rtl/spi_edge_sync.sv
// Synchronizes the raw SPI pins into inclk and flags SCK / SS edges.
// SCK, SS and MOSI share the same chain depth so a sampled MOSI bit lines
// up with the SCK rise it belongs to.
module spi_edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic inclk,
    input  logic Reset_n,
    input  logic i_sck,
    input  logic i_mosi,
    input  logic i_ss,
    output logic o_mosi,
    output logic o_sck_rise,
    output logic o_sck_fall,
    output logic o_ss_fall,
    output logic o_ss_rise
);

    logic [SYNC_STAGES-1:0] r_sck_sync;
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic [SYNC_STAGES-1:0] r_ss_sync;
    logic                   r_sck_d;
    logic                   r_ss_d;
    logic                   w_sck;
    logic                   w_ss;

    // Synchronizer chains plus one history flop for edge detection; SS idles high
    always_ff @(posedge inclk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_sck_sync  <= '0;
            r_mosi_sync <= '0;
            r_ss_sync   <= '1;
            r_sck_d     <= 1'b0;
            r_ss_d      <= 1'b1;
        end else begin
            r_sck_sync[0]  <= i_sck;
            r_mosi_sync[0] <= i_mosi;
            r_ss_sync[0]   <= i_ss;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_sck_sync[i]  <= r_sck_sync[i-1];
                r_mosi_sync[i] <= r_mosi_sync[i-1];
                r_ss_sync[i]   <= r_ss_sync[i-1];
            end
            r_sck_d <= w_sck;
            r_ss_d  <= w_ss;
        end
    end

    assign w_sck      = r_sck_sync[SYNC_STAGES-1];
    assign w_ss       = r_ss_sync[SYNC_STAGES-1];
    assign o_mosi     = r_mosi_sync[SYNC_STAGES-1];
    assign o_sck_rise =  w_sck & ~r_sck_d;
    assign o_sck_fall = ~w_sck &  r_sck_d;
    assign o_ss_fall  = ~w_ss  &  r_ss_d;
    assign o_ss_rise  =  w_ss  & ~r_ss_d;

endmodule

// File: rtl/spi_cmd_slave.sv
// SPI mode-0 responder for the host link. Decodes the opcode byte of each
// SS frame, collects command/data words, serves the response register and
// streams capture bytes from the show-ahead FIFO. Everything runs on inclk.
module spi_cmd_slave
    import spi_proto_pkg::*;
#(
    parameter int SPI_BUF_WIDTH = 4,
    parameter int SYNC_STAGES   = 2
) (
    input  logic        inclk,
    input  logic        Reset_n,
    input  logic        SPI_CLK,
    input  logic        SPI_MOSI,
    output logic        SPI_MISO,
    input  logic        SPI_SS,
    output logic [31:0] cmd_word,
    output logic        cmd_valid,
    output logic [31:0] data_word,
    output logic        data_valid,
    input  logic [31:0] resp_word,
    input  logic [7:0]  fifo_data,
    input  logic        fifo_empty,
    output logic        fifo_rd_en
);

    // Byte counter includes the opcode byte, so a complete write frame
    // reaches SPI_BUF_WIDTH+1, which is also where it saturates.
    localparam int              BCW      = $clog2(SPI_BUF_WIDTH + 2);
    localparam logic [BCW-1:0]  BYTE_MAX = BCW'(SPI_BUF_WIDTH + 1);
    localparam logic [BCW-1:0]  BYTE_ONE = BCW'(1);

    logic            w_mosi;
    logic            w_sck_rise;
    logic            w_sck_fall;
    logic            w_ss_fall;
    logic            w_ss_rise;
    logic            w_payload;
    logic            w_wr_state;

    spi_state_e      r_state;
    logic [2:0]      r_bit_cnt;
    logic [BCW-1:0]  r_byte_cnt;
    logic [6:0]      r_op;
    logic [31:0]     r_rx;
    logic [31:0]     r_tx;
    logic            r_miso;
    logic [31:0]     r_cmd_word;
    logic            r_cmd_valid;
    logic [31:0]     r_data_word;
    logic            r_data_valid;
    logic            r_fifo_rd_en;

    spi_edge_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .inclk      (inclk),
        .Reset_n    (Reset_n),
        .i_sck      (SPI_CLK),
        .i_mosi     (SPI_MOSI),
        .i_ss       (SPI_SS),
        .o_mosi     (w_mosi),
        .o_sck_rise (w_sck_rise),
        .o_sck_fall (w_sck_fall),
        .o_ss_fall  (w_ss_fall),
        .o_ss_rise  (w_ss_rise)
    );

    assign w_payload  = (r_byte_cnt != '0) && (r_byte_cnt < BYTE_MAX);
    assign w_wr_state = (r_state == ST_WR_CMD) || (r_state == ST_WR_DATA);

    // Frame FSM and bit/byte counters; SS rise overrides any same-cycle SCK edge
    always_ff @(posedge inclk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state    <= ST_IDLE;
            r_bit_cnt  <= 3'd0;
            r_byte_cnt <= '0;
            r_op       <= 7'd0;
        end else if (w_ss_rise) begin
            r_state <= ST_IDLE;
        end else if (w_ss_fall) begin
            r_state    <= ST_OPCODE;
            r_bit_cnt  <= 3'd0;
            r_byte_cnt <= '0;
        end else if (w_sck_rise && (r_state != ST_IDLE)) begin
            r_bit_cnt <= r_bit_cnt + 3'd1;
            if ((r_bit_cnt == 3'd7) && (r_byte_cnt != BYTE_MAX))
                r_byte_cnt <= r_byte_cnt + BYTE_ONE;
            if (r_state == ST_OPCODE) begin
                r_op <= {r_op[5:0], w_mosi};
                if (r_bit_cnt == 3'd7)
                    r_state <= decode_opcode({r_op, w_mosi});
            end
        end
    end

    // Receive shifter for write frames; commit only full frames at SS rise
    always_ff @(posedge inclk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_rx         <= 32'd0;
            r_cmd_word   <= 32'd0;
            r_cmd_valid  <= 1'b0;
            r_data_word  <= 32'd0;
            r_data_valid <= 1'b0;
        end else begin
            r_cmd_valid  <= 1'b0;
            r_data_valid <= 1'b0;
            if (w_ss_rise) begin
                if (r_byte_cnt == BYTE_MAX) begin
                    if (r_state == ST_WR_CMD) begin
                        r_cmd_word  <= r_rx;
                        r_cmd_valid <= 1'b1;
                    end else if (r_state == ST_WR_DATA) begin
                        r_data_word  <= r_rx;
                        r_data_valid <= 1'b1;
                    end
                end
            end else if (w_ss_fall) begin
                r_rx <= 32'd0;
            end else if (w_sck_rise && w_wr_state && w_payload) begin
                r_rx <= {r_rx[30:0], w_mosi};
            end
        end
    end

    // Transmit path: MISO moves on SCK fall (or is cleared on SS fall).
    // The fall with bit_cnt==0 is a byte boundary; RD_RESP snapshots resp_word
    // at the first one, RD_STREAM reloads from the FIFO at every one.
    always_ff @(posedge inclk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_tx         <= 32'd0;
            r_miso       <= 1'b0;
            r_fifo_rd_en <= 1'b0;
        end else begin
            r_fifo_rd_en <= 1'b0;
            if (w_ss_rise) begin
                r_tx <= 32'd0;
            end else if (w_ss_fall) begin
                r_tx   <= 32'd0;
                r_miso <= 1'b0;
            end else if (w_sck_fall) begin
                case (r_state)
                    ST_RD_RESP: begin
                        if ((r_bit_cnt == 3'd0) && (r_byte_cnt == BYTE_ONE)) begin
                            r_miso <= resp_word[31];
                            r_tx   <= {resp_word[30:0], 1'b0};
                        end else begin
                            r_miso <= r_tx[31];
                            r_tx   <= {r_tx[30:0], 1'b0};
                        end
                    end
                    ST_RD_STREAM: begin
                        if (r_bit_cnt == 3'd0) begin
                            if (!fifo_empty) begin
                                r_miso       <= fifo_data[7];
                                r_tx         <= {fifo_data[6:0], 25'd0};
                                r_fifo_rd_en <= 1'b1;
                            end else begin
                                r_miso <= 1'b0;
                                r_tx   <= 32'd0;
                            end
                        end else begin
                            r_miso <= r_tx[31];
                            r_tx   <= {r_tx[30:0], 1'b0};
                        end
                    end
                    default: begin
                        r_miso <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign SPI_MISO   = r_miso;
    assign cmd_word   = r_cmd_word;
    assign cmd_valid  = r_cmd_valid;
    assign data_word  = r_data_word;
    assign data_valid = r_data_valid;
    assign fifo_rd_en = r_fifo_rd_en;

endmodule

// File: tb/tb_spi_cmd_slave.sv
// Directed bench for spi_cmd_slave: drives host SPI frames at 1/10 of inclk
// and checks strobes, words, MISO bytes and FIFO pops against hand values.
module tb_spi_cmd_slave;

    localparam int H = 50;  // SCK half period in ns (inclk period 10 ns)

    logic        inclk = 1'b0;
    logic        Reset_n;
    logic        SPI_CLK;
    logic        SPI_MOSI;
    logic        SPI_MISO;
    logic        SPI_SS;
    logic [31:0] cmd_word;
    logic        cmd_valid;
    logic [31:0] data_word;
    logic        data_valid;
    logic [31:0] resp_word;
    logic [7:0]  fifo_data;
    logic        fifo_empty;
    logic        fifo_rd_en;

    int tests = 0;
    int fails = 0;

    logic [7:0] tx_q [0:31];
    logic [7:0] rx_q [0:31];

    // Show-ahead FIFO model
    logic [7:0] fifo_mem [0:15];
    int fifo_cnt = 0;
    int fifo_idx = 0;

    // Event counters sampled on the active edge
    int cmd_cnt   = 0;
    int data_cnt  = 0;
    int pop_cnt   = 0;
    int pop_empty = 0;
    int both_cnt  = 0;

    always #5 inclk = ~inclk;

    assign fifo_empty = (fifo_idx >= fifo_cnt);
    assign fifo_data  = fifo_empty ? 8'h00 : fifo_mem[fifo_idx[3:0]];

    always @(posedge inclk) begin
        if (cmd_valid)  cmd_cnt  <= cmd_cnt + 1;
        if (data_valid) data_cnt <= data_cnt + 1;
        if (cmd_valid && data_valid) both_cnt <= both_cnt + 1;
        if (fifo_rd_en) begin
            pop_cnt <= pop_cnt + 1;
            if (fifo_empty) pop_empty <= pop_empty + 1;
            else            fifo_idx  <= fifo_idx + 1;
        end
    end

    spi_cmd_slave dut (
        .inclk      (inclk),
        .Reset_n    (Reset_n),
        .SPI_CLK    (SPI_CLK),
        .SPI_MOSI   (SPI_MOSI),
        .SPI_MISO   (SPI_MISO),
        .SPI_SS     (SPI_SS),
        .cmd_word   (cmd_word),
        .cmd_valid  (cmd_valid),
        .data_word  (data_word),
        .data_valid (data_valid),
        .resp_word  (resp_word),
        .fifo_data  (fifo_data),
        .fifo_empty (fifo_empty),
        .fifo_rd_en (fifo_rd_en)
    );

    // One byte, MSB first; MISO captured just before each SCK rise
    task automatic send_byte(input logic [7:0] b, output logic [7:0] r);
        for (int i = 7; i >= 0; i--) begin
            SPI_MOSI = b[i];
            #H;
            r[i] = SPI_MISO;
            SPI_CLK = 1'b1;
            #H;
            SPI_CLK = 1'b0;
        end
    endtask

    task automatic frame(input int n);
        SPI_SS = 1'b0;
        #H;
        for (int k = 0; k < n; k++) send_byte(tx_q[k], rx_q[k]);
        #H;
        SPI_SS = 1'b1;
        #(4*H);
    endtask

    task automatic load5(input logic [7:0] a, b, c, d, e);
        tx_q[0] = a; tx_q[1] = b; tx_q[2] = c; tx_q[3] = d; tx_q[4] = e;
    endtask

    task automatic test_reset();
        Reset_n = 1'b0; SPI_SS = 1'b1; SPI_CLK = 1'b0; SPI_MOSI = 1'b0;
        resp_word = 32'd0;
        #30;
        tests++; if (SPI_MISO !== 1'b0) begin fails++; $display("FAIL reset_miso got %b want 0", SPI_MISO); end
        tests++; if (cmd_word !== 32'd0) begin fails++; $display("FAIL reset_cmd_word got %h want 0", cmd_word); end
        tests++; if (data_word !== 32'd0) begin fails++; $display("FAIL reset_data_word got %h want 0", data_word); end
        tests++; if (cmd_valid !== 1'b0) begin fails++; $display("FAIL reset_cmd_valid got %b want 0", cmd_valid); end
        tests++; if (data_valid !== 1'b0) begin fails++; $display("FAIL reset_data_valid got %b want 0", data_valid); end
        tests++; if (fifo_rd_en !== 1'b0) begin fails++; $display("FAIL reset_fifo_rd_en got %b want 0", fifo_rd_en); end
        Reset_n = 1'b1;
        #(4*H);
    endtask

    task automatic test_cmd_write();
        int c0, d0;
        c0 = cmd_cnt; d0 = data_cnt;
        load5(8'hC0, 8'h00, 8'h00, 8'h00, 8'h06);
        frame(5);
        tests++; if (cmd_cnt - c0 !== 1) begin fails++; $display("FAIL cmd_strobe_cycles got %0d want 1", cmd_cnt - c0); end
        tests++; if (cmd_word !== 32'd6) begin fails++; $display("FAIL cmd_word got %h want 00000006", cmd_word); end
        tests++; if (data_cnt - d0 !== 0) begin fails++; $display("FAIL cmd_no_data_strobe got %0d want 0", data_cnt - d0); end
    endtask

    task automatic test_data_write();
        int d0;
        d0 = data_cnt;
        load5(8'hC2, 8'h00, 8'h03, 8'h00, 8'h00);
        frame(5);
        tests++; if (data_cnt - d0 !== 1) begin fails++; $display("FAIL data_strobe_cycles got %0d want 1", data_cnt - d0); end
        tests++; if (data_word !== 32'h00030000) begin fails++; $display("FAIL data_word got %h want 00030000", data_word); end
        d0 = data_cnt;
        load5(8'hC2, 8'hFF, 8'hFF, 8'h00, 8'h00);
        frame(3);
        tests++; if (data_cnt - d0 !== 0) begin fails++; $display("FAIL short_frame_strobe got %0d want 0", data_cnt - d0); end
        tests++; if (data_word !== 32'h00030000) begin fails++; $display("FAIL short_frame_word got %h want 00030000", data_word); end
    endtask

    task automatic test_resp_read();
        logic [7:0] exp [0:4];
        exp[0] = 8'h00; exp[1] = 8'h00; exp[2] = 8'h00; exp[3] = 8'h00; exp[4] = 8'h05;
        resp_word = 32'd5;
        load5(8'h81, 8'h00, 8'h00, 8'h00, 8'h00);
        frame(5);
        for (int k = 0; k < 5; k++) begin
            tests++; if (rx_q[k] !== exp[k]) begin fails++; $display("FAIL resp_byte%0d got %h want %h", k, rx_q[k], exp[k]); end
        end
        // Change resp_word after the opcode byte: the snapshot must hold
        fork
            frame(5);
            begin #(19*H); resp_word = 32'd6; end
        join
        for (int k = 1; k < 5; k++) begin
            tests++; if (rx_q[k] !== exp[k]) begin fails++; $display("FAIL resp_snap_byte%0d got %h want %h", k, rx_q[k], exp[k]); end
        end
    endtask

    task automatic test_stream();
        int p0;
        for (int i = 0; i < 16; i++) fifo_mem[i] = 8'(8'h10 + i);
        fifo_cnt = 16;
        tx_q[0] = 8'h03;
        for (int k = 1; k < 18; k++) tx_q[k] = 8'h00;
        p0 = pop_cnt;
        frame(18);
        for (int k = 1; k < 17; k++) begin
            tests++; if (rx_q[k] !== 8'(8'h10 + k - 1)) begin fails++; $display("FAIL stream_byte%0d got %h want %h", k, rx_q[k], 8'(8'h10 + k - 1)); end
        end
        tests++; if (rx_q[17] !== 8'h00) begin fails++; $display("FAIL stream_empty_byte got %h want 00", rx_q[17]); end
        tests++; if (rx_q[0] !== 8'h00) begin fails++; $display("FAIL stream_opcode_miso got %h want 00", rx_q[0]); end
        tests++; if (pop_cnt - p0 !== 16) begin fails++; $display("FAIL stream_pops got %0d want 16", pop_cnt - p0); end
        tests++; if (pop_empty !== 0) begin fails++; $display("FAIL stream_pop_on_empty got %0d want 0", pop_empty); end
    endtask

    task automatic test_discard();
        int c0, d0, p0;
        c0 = cmd_cnt; d0 = data_cnt; p0 = pop_cnt;
        load5(8'h55, 8'hAA, 8'hFF, 8'h12, 8'h34);
        frame(5);
        for (int k = 0; k < 5; k++) begin
            tests++; if (rx_q[k] !== 8'h00) begin fails++; $display("FAIL discard_miso%0d got %h want 00", k, rx_q[k]); end
        end
        tests++; if ((cmd_cnt - c0) + (data_cnt - d0) !== 0) begin fails++; $display("FAIL discard_strobes got %0d want 0", (cmd_cnt - c0) + (data_cnt - d0)); end
        tests++; if (pop_cnt - p0 !== 0) begin fails++; $display("FAIL discard_pops got %0d want 0", pop_cnt - p0); end
        c0 = cmd_cnt;
        load5(8'hC0, 8'h00, 8'h00, 8'h00, 8'h09);
        frame(5);
        tests++; if (cmd_word !== 32'd9) begin fails++; $display("FAIL after_discard_cmd got %h want 00000009", cmd_word); end
        tests++; if (cmd_cnt - c0 !== 1) begin fails++; $display("FAIL after_discard_strobe got %0d want 1", cmd_cnt - c0); end
    endtask

    task automatic test_reset_midframe();
        logic [7:0] r;
        int c0;
        c0 = cmd_cnt;
        SPI_SS = 1'b0;
        #H;
        send_byte(8'hC0, r);
        send_byte(8'h00, r);
        Reset_n = 1'b0;
        #1;
        tests++; if (cmd_word !== 32'd0) begin fails++; $display("FAIL midreset_async_cmd got %h want 0", cmd_word); end
        #19;
        tests++; if (data_word !== 32'd0) begin fails++; $display("FAIL midreset_data_word got %h want 0", data_word); end
        tests++; if ({SPI_MISO, cmd_valid, data_valid, fifo_rd_en} !== 4'b0000) begin
            fails++; $display("FAIL midreset_bits got %b want 0000", {SPI_MISO, cmd_valid, data_valid, fifo_rd_en});
        end
        Reset_n = 1'b1;
        #H;
        SPI_SS = 1'b1;
        #(4*H);
        load5(8'hC0, 8'h00, 8'h00, 8'h00, 8'h01);
        frame(5);
        tests++; if (cmd_word !== 32'd1) begin fails++; $display("FAIL post_reset_cmd got %h want 00000001", cmd_word); end
        tests++; if (cmd_cnt - c0 !== 1) begin fails++; $display("FAIL post_reset_strobes got %0d want 1", cmd_cnt - c0); end
    endtask

    initial begin
        test_reset();
        test_cmd_write();
        test_data_write();
        test_resp_read();
        test_stream();
        test_discard();
        test_reset_midframe();
        tests++; if (both_cnt !== 0) begin fails++; $display("FAIL dual_strobe got %0d want 0", both_cnt); end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/spi_cmd_slave.md
Name: spi_cmd_slave

Overview:
- SPI responder (mode 0, MSB first) inside the instrument; terminates the host's framed protocol: command write, data write, response read, capture-buffer stream read.
- Converts frames into single-cycle strobes for the controller and pulls capture bytes from the show-ahead FIFO.
- Runs entirely on inclk; SPI_CLK, SPI_MOSI and SPI_SS are oversampled and treated as data.

Parameters:
- SPI_BUF_WIDTH, 4, payload bytes following the opcode in fixed-length frames.
- SYNC_STAGES, 2, synchronizer flops on SPI_CLK, SPI_MOSI and SPI_SS.

Ports:
- inclk  in  1  system clock; must be at least 8x SPI_CLK frequency.
- Reset_n  in  1  asynchronous, active-low reset.
- SPI_CLK  in  1  host serial clock, idles low.
- SPI_MOSI  in  1  host data.
- SPI_MISO  out  1  responder data.
- SPI_SS  in  1  active-low frame select.
- cmd_word  out  32  last committed command word.
- cmd_valid  out  1  one-cycle strobe when cmd_word updates.
- data_word  out  32  last committed data word (argument for ARM_ON_STEP/SET_* commands).
- data_valid  out  1  one-cycle strobe when data_word updates.
- resp_word  in  32  controller response register.
- fifo_data  in  8  show-ahead FIFO head.
- fifo_empty  in  1  FIFO empty.
- fifo_rd_en  out  1  one-cycle pop.

Behaviour:
- Reset values: SPI_MISO=0, cmd_word=0, data_word=0, cmd_valid=0, data_valid=0, fifo_rd_en=0, FSM in IDLE. Reset takes effect mid-frame immediately; the partial frame is discarded.
- Input sampling: SPI inputs pass through SYNC_STAGES flops. Rising and falling SCK edges and the SS fall/rise are detected on synchronized values.
- MOSI is sampled on the SCK rise. MISO changes only on the SCK fall and on the SS fall.
- Bit counter: 3-bit, cleared on SS fall. Byte counter saturates at SPI_BUF_WIDTH+1.
- FSM states: IDLE -> OPCODE on SS fall. After the 8th bit the opcode selects the next state:
  - 0xC0 -> WR_CMD
  - 0xC2 -> WR_DATA
  - 0x81 -> RD_RESP
  - 0x03 -> RD_STREAM
  - any other opcode -> DISCARD (MISO held 0, no strobes).
- Any state -> IDLE on SS rise.
- WR_CMD / WR_DATA: shift in a 32-bit word, MSB first.
  - Commit on SS rise only if at least SPI_BUF_WIDTH payload bytes completed. Strobe asserts 1 cycle after the SS rise is detected.
  - Bytes beyond SPI_BUF_WIDTH are ignored. Short frames are discarded with no strobe.
- RD_RESP: resp_word is snapshotted on the SCK fall ending the opcode byte. Bits are shifted out MSB first; after 32 bits MISO=0.
- RD_STREAM: on each byte boundary (SCK fall after bit 8 of the previous byte):
  - fifo not empty: load fifo_data into the TX shifter and pulse fifo_rd_en for one cycle.
  - fifo empty: load 0x00, no pop.
  - Unlimited length; one pop per byte boundary, never more.
- During the opcode byte MISO=0.
- Simultaneous SS rise and SCK edge in the same cycle: SS rise wins and the edge is ignored.
- SS rise mid-byte in RD_STREAM: the popped byte is lost. No rollback.
- cmd_valid and data_valid never assert in the same cycle (one frame per SS).

Decomposition:
- Package spi_proto_pkg holds:
  - opcode constants: OP_WR_CMD=8'hC0, OP_WR_DATA=8'hC2, OP_RD_RESP=8'h81, OP_RD_STREAM=8'h03.
  - CMD_* and RESP_* 32-bit codes 0..14.
  - FSM state enum.
- Sub-module spi_edge_sync: synchronizers plus rise/fall detect for SCK and SS. The top level holds the FSM and shifters.

Test Plan:
- Frame C0 00 00 00 06 -> cmd_valid one cycle, cmd_word=32'd6; data_valid stays 0.
- Frame C2 00 03 00 00 -> data_valid, data_word=32'h00030000. A following 3-byte frame C2 FF FF -> no strobe, data_word unchanged.
- resp_word=32'd5, frame 81 00 00 00 00 -> MISO bytes 00 00 00 00 05 across the frame. resp_word changed to 6 after the opcode byte -> still reads 05.
- FIFO preloaded 10 11 ... 1F (16 bytes), frame 03 followed by 17 dummy bytes:
  - bytes 10..1F returned in order, then 00.
  - exactly 16 fifo_rd_en pulses; fifo_empty respected.
- Opcode 0x55 with 4 bytes -> MISO=0 throughout, no strobes, no pops. A subsequent valid C0 frame is decoded normally.
- Reset_n low for 2 cycles midway through a C0 frame -> all outputs at reset values. The next full frame C0 00 00 00 01 -> cmd_word=1.
